amiq_fifo_sync_core: RTL and testbench

- Synchronous single-clock FIFO storage core; the responder behind the FIFO read interface.
- Accepts producer writes (wr_en/wr_data) and answers consumer reads (rd_en) with registered rd_data plus a qualifying rd_valid.
- Sits between the write agent's DUT-side pins and the read interface; it is the DUT the read agent drives and monitors.

---
 rtl/amiq_fifo_pkg.sv | 30 +++
 rtl/amiq_fifo_mem.sv | 54 +++++
 rtl/amiq_fifo_sync_core.sv | 143 ++++++++++++++
 tb/tb_amiq_fifo_sync_core.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/amiq_fifo_pkg.sv
// -----------------------------------------------------------------------------
// amiq_fifo_pkg
// Shared defaults and helpers for the synchronous FIFO storage core.
//   - DEF_M / DEF_DEPTH      : default data width and entry count
//   - DEF_AF_LEVEL / AE_LEVEL: default almost-full / almost-empty thresholds
//   - level_t                : occupancy type for the default geometry
//   - fifo_level()           : occupancy from a write/read pointer pair
// -----------------------------------------------------------------------------
package amiq_fifo_pkg;

    localparam int DEF_M        = 8;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_AF_LEVEL = DEF_DEPTH - 2;
    localparam int DEF_AE_LEVEL = 2;
    localparam int DEF_AW       = $clog2(DEF_DEPTH);

    typedef logic [DEF_AW:0] level_t;

    // Pointers carry one extra wrap bit, so the difference taken modulo
    // 2^(aw+1) is the occupancy even after the write pointer has wrapped
    // and the read pointer has not.
    function automatic logic [31:0] fifo_level(input logic [31:0] wr_ptr,
                                               input logic [31:0] rd_ptr,
                                               input int          aw);
        logic [31:0] mask;
        mask = (32'd1 << (aw + 1)) - 32'd1;
        return (wr_ptr - rd_ptr) & mask;
    endfunction

endpackage

// File: rtl/amiq_fifo_mem.sv
// -----------------------------------------------------------------------------
// amiq_fifo_mem
// DEPTH x M register array with one write port and one registered read port.
//   clk, rst : clock, async active-high reset (resets only the read register)
//   we, waddr, wdata : write port, stored on the rising edge when we=1
//   re, raddr        : read request, rdata loads mem[raddr] on the edge
//   rdata            : registered read data, holds when re=0
// -----------------------------------------------------------------------------
module amiq_fifo_mem #(
    parameter  int M     = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [M-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [M-1:0]  rdata
);

    logic [M-1:0] mem_q [DEPTH];
    logic [M-1:0] rdata_q;
    logic [M-1:0] rdata_d;

    // Storage is deliberately left unreset; only the visible read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // A read and a write to the same address in one cycle returns the old
    // word, which is what the core relies on when popping while full.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/amiq_fifo_sync_core.sv
// -----------------------------------------------------------------------------
// amiq_fifo_sync_core
// Single-clock FIFO: pointers, registered status flags and sticky error flags
// around an amiq_fifo_mem storage array.
//   clk, rst      : clock, async active-high reset
//   wr_en/wr_data : producer write; accepted when not full or when a read
//                   is accepted in the same cycle
//   rd_en         : consumer read; accepted when not empty
//   rd_data       : registered data, valid one cycle after an accepted read
//   rd_valid      : rd_data carries a newly popped word this cycle
//   full/empty/almost_full/almost_empty/level : registered occupancy status
//   overflow/underflow : sticky rejected-write / rejected-read flags
//   clr_err       : synchronous clear of both sticky flags (wins over a set)
// -----------------------------------------------------------------------------
module amiq_fifo_sync_core
    import amiq_fifo_pkg::*;
#(
    parameter  int M        = DEF_M,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int AF_LEVEL = DEPTH - 2,
    parameter  int AE_LEVEL = DEF_AE_LEVEL,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [M-1:0] wr_data,
    input  logic         rd_en,
    output logic [M-1:0] rd_data,
    output logic         rd_valid,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic         almost_empty,
    output logic [AW:0]  level,
    output logic         overflow,
    output logic         underflow,
    input  logic         clr_err
);

    localparam logic [AW:0] AF_LVL = (AW + 1)'(AF_LEVEL);
    localparam logic [AW:0] AE_LVL = (AW + 1)'(AE_LEVEL);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q, level_d;
    logic        full_q, full_d;
    logic        empty_q, empty_d;
    logic        almost_full_q, almost_full_d;
    logic        almost_empty_q, almost_empty_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;
    logic        rd_valid_q, rd_valid_d;
    logic        wr_acc;
    logic        rd_acc;

    // All flags are computed from the next-state pointers so that the
    // registered outputs describe the occupancy after this cycle's update.
    always_comb begin
        rd_acc = rd_en & ~empty_q;
        // A pop frees a slot in the same cycle, so a full FIFO still takes
        // a write when a read is accepted alongside it.
        wr_acc = wr_en & (~full_q | rd_acc);

        wr_ptr_d = wr_ptr_q + (AW + 1)'(wr_acc);
        rd_ptr_d = rd_ptr_q + (AW + 1)'(rd_acc);
        level_d  = (AW + 1)'(fifo_level(32'(wr_ptr_d), 32'(rd_ptr_d), AW));

        full_d         = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                         (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        empty_d        = (wr_ptr_d == rd_ptr_d);
        almost_full_d  = (level_d >= AF_LVL);
        almost_empty_d = (level_d <= AE_LVL);
        rd_valid_d     = rd_acc;

        // Clear is evaluated last so it overrides an error raised this cycle.
        overflow_d = overflow_q;
        if (wr_en & ~wr_acc) begin
            overflow_d = 1'b1;
        end
        if (clr_err) begin
            overflow_d = 1'b0;
        end

        underflow_d = underflow_q;
        if (rd_en & ~rd_acc) begin
            underflow_d = 1'b1;
        end
        if (clr_err) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            rd_valid_q     <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            rd_valid_q     <= rd_valid_d;
        end
    end

    amiq_fifo_mem #(
        .M     (M),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (wr_data),
        .re    (rd_acc),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_data)
    );

    assign rd_valid     = rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_amiq_fifo_sync_core.sv
// -----------------------------------------------------------------------------
// tb_amiq_fifo_sync_core
// Directed bench for amiq_fifo_sync_core (M=8, DEPTH=16). Stimulus pushes the
// word each accepted read must return into a queue; a negedge monitor pops
// and compares whenever rd_valid is high. Status outputs are compared against
// hand-derived constants after each stimulus cycle.
// -----------------------------------------------------------------------------
module tb_amiq_fifo_sync_core;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] level;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    // Words stored in the FIFO, and words that reads have been issued for.
    logic [7:0] stored_q [$];
    logic [7:0] exp_q [$];

    amiq_fifo_sync_core dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs starting just after a rising edge, tracks
    // which requests the FIFO must accept, and returns 1 time unit after the
    // capturing edge so status outputs can be compared.
    task automatic applyStimulus(input logic we, input logic [7:0] wd,
                                 input logic re, input logic ce);
        bit rd_ok;
        bit wr_ok;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        clr_err = ce;
        rd_ok = re && (stored_q.size() > 0);
        wr_ok = we && ((stored_q.size() < 16) || rd_ok);
        if (rd_ok) exp_q.push_back(stored_q.pop_front());
        if (wr_ok) stored_q.push_back(wd);
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    // Monitor: every presented word must match the oldest outstanding read.
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_rd_valid", 32'(rd_valid), 32'd0);
            end else begin
                checkOutput("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] cnt;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset values
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_aempty", 32'(almost_empty), 32'd1);
        checkOutput("rst_afull", 32'(almost_full), 32'd0);
        checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
        checkOutput("rst_ovf", 32'(overflow), 32'd0);
        checkOutput("rst_udf", 32'(underflow), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fill with 0x01..0x10
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b1, 8'(k), 1'b0, 1'b0);
            checkOutput("fill_level", 32'(level), 32'(k));
            checkOutput("fill_afull", 32'(almost_full), 32'(k >= 14));
            checkOutput("fill_aempty", 32'(almost_empty), 32'(k <= 2));
        end
        checkOutput("fill_full", 32'(full), 32'd1);
        checkOutput("fill_ovf", 32'(overflow), 32'd0);

        // Write while full is dropped
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        checkOutput("ovf_set", 32'(overflow), 32'd1);
        checkOutput("ovf_level", 32'(level), 32'd16);

        // Drain; the monitor expects 0x01..0x10
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("drain_level", 32'(level), 32'(16 - k));
        end
        checkOutput("drain_empty", 32'(empty), 32'd1);
        checkOutput("drain_udf", 32'(underflow), 32'd0);

        // Read while empty
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("udf_set", 32'(underflow), 32'd1);
        checkOutput("udf_level", 32'(level), 32'd0);

        // clr_err wins over a same-cycle underflow
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("clr_ovf", 32'(overflow), 32'd0);
        checkOutput("clr_udf_prio", 32'(underflow), 32'd0);

        // Wrap: bursts of 10 writes / 10 reads with counting data
        cnt = 8'h20;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 10; k++) begin
                applyStimulus(1'b1, cnt, 1'b0, 1'b0);
                cnt = cnt + 8'd1;
            end
            checkOutput("wrap_level_peak", 32'(level), 32'd10);
            for (int k = 0; k < 10; k++) begin
                applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            end
            checkOutput("wrap_level_end", 32'(level), 32'd0);
        end

        // Full with simultaneous read and write
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, 8'(8'h80 + k), 1'b0, 1'b0);
        end
        checkOutput("full_pre", 32'(full), 32'd1);
        applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
        checkOutput("full_rw_level", 32'(level), 32'd16);
        checkOutput("full_rw_full", 32'(full), 32'd1);
        checkOutput("full_rw_ovf", 32'(overflow), 32'd0);
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("full_rw_drained", 32'(empty), 32'd1);

        // Empty with simultaneous read and write
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
        checkOutput("empty_rw_udf", 32'(underflow), 32'd1);
        checkOutput("empty_rw_level", 32'(level), 32'd1);
        checkOutput("empty_rw_empty", 32'(empty), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("empty_rw_after", 32'(level), 32'd0);

        // Async reset with level = 7
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b1, 8'(8'h40 + k), 1'b0, 1'b0);
        end
        checkOutput("mid_level", 32'(level), 32'd7);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_level", 32'(level), 32'd0);
        checkOutput("async_empty", 32'(empty), 32'd1);
        checkOutput("async_aempty", 32'(almost_empty), 32'd1);
        checkOutput("async_udf", 32'(underflow), 32'd0);
        checkOutput("async_rd_data", 32'(rd_data), 32'd0);
        stored_q.delete();
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("post_rst_udf", 32'(underflow), 32'd1);
        checkOutput("post_rst_valid", 32'(rd_valid), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("post_clr_udf", 32'(underflow), 32'd0);
        checkOutput("post_clr_ovf", 32'(overflow), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
